// File: rtl/bus_copy_if.sv
// Single-cycle enable/write/wait bus between the copy master and the arbiter port.
interface bus_copy_if;
  logic        busEnable;
  logic        busWrite;
  logic [31:0] busAddress;
  logic [31:0] busWriteData;
  logic [31:0] busReadData;
  logic        busWait;

  modport master (
    output busEnable, busWrite, busAddress, busWriteData,
    input  busReadData, busWait
  );

  modport slave (
    input  busEnable, busWrite, busAddress, busWriteData,
    output busReadData, busWait
  );
endinterface

// File: rtl/bus_copy_master.sv
// Block copy initiator: one read then one write per 32-bit word, with wait-state timeout.
// state | meaning
// IDLE  | no transfer on the bus; accepts start
// READ  | read of the current source word presented
// WRITE | write of the buffered word to the current destination presented
module bus_copy_master #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            sourceAddress,
  input  logic [31:0]            destinationAddress,
  input  logic [COUNT_WIDTH-1:0] wordCount,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  bus_copy_if.master             bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]            wait_q, wait_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   en_q, en_d;
  logic                   we_q, we_d;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{sourceAddress[1:0], destinationAddress[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      en_q    <= en_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    en_d    = en_q;
    we_d    = we_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (wordCount == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
            src_d   = {sourceAddress[31:2], 2'b00};
            dst_d   = {destinationAddress[31:2], 2'b00};
            addr_d  = {sourceAddress[31:2], 2'b00};
            cnt_d   = wordCount;
            wait_d  = TIMEOUT_CYCLES;
            busy_d  = 1'b1;
            en_d    = 1'b1;
            we_d    = 1'b0;
          end
        end
      end

      READ, WRITE: begin
        if (bus.busWait) begin
          // wait_q counts down the stall budget left for the current transfer
          if (wait_q <= 16'd1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            en_d    = 1'b0;
            we_d    = 1'b0;
            error_d = 1'b1;
          end else begin
            wait_d = wait_q - 16'd1;
          end
        end else if (state_q == READ) begin
          state_d = WRITE;
          wdata_d = bus.busReadData;
          addr_d  = dst_q;
          we_d    = 1'b1;
          wait_d  = TIMEOUT_CYCLES;
        end else begin
          cnt_d  = cnt_q - COUNT_WIDTH'(1);
          src_d  = src_q + 32'd4;
          dst_d  = dst_q + 32'd4;
          wait_d = TIMEOUT_CYCLES;
          if (cnt_q == COUNT_WIDTH'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            en_d    = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            addr_d  = src_q + 32'd4;
            we_d    = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign bus.busEnable    = en_q;
  assign bus.busWrite     = we_q;
  assign bus.busAddress   = addr_q;
  assign bus.busWriteData = wdata_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed bench for bus_copy_master: copies, wait states, timeout, wrap, zero count, reset.
module tb_bus_copy_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_a;
  logic [31:0] dst_a;
  logic [15:0] wcnt;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  bus_copy_if bus ();

  bus_copy_master #(
    .TIMEOUT_CYCLES (16'd4),
    .COUNT_WIDTH    (16)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .sourceAddress      (src_a),
    .destinationAddress (dst_a),
    .wordCount          (wcnt),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .bus                (bus)
  );

  int errors = 0;
  int checks = 0;

  logic        lg_en   [0:15];
  logic        lg_we   [0:15];
  logic        lg_busy [0:15];
  logic        lg_done [0:15];
  logic        lg_err  [0:15];
  logic [31:0] lg_addr [0:15];
  logic [31:0] lg_wd   [0:15];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Cycle k=1 is the cycle after the edge that samples start.
  // Slave stalls for k in [wfrom, wto]; start is re-pulsed in cycle rp.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input int ncyc, input int wfrom, input int wto, input int rp);
    src_a        = s;
    dst_a        = d;
    wcnt         = n;
    start        = 1'b1;
    bus.busWait  = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      lg_en[k]   = bus.busEnable;
      lg_we[k]   = bus.busWrite;
      lg_addr[k] = bus.busAddress;
      lg_wd[k]   = bus.busWriteData;
      lg_busy[k] = busy;
      lg_done[k] = done;
      lg_err[k]  = error;
      start      = (k == rp);
      if (k == rp) begin
        src_a = 32'h0000_0F00;
        wcnt  = 16'd7;
      end
      bus.busWait     = (k >= wfrom && k <= wto);
      bus.busReadData = bus.busWait ? (32'hDEAD_0000 | 32'(k)) : data_of(bus.busAddress);
    end
    bus.busWait = 1'b0;
    start       = 1'b0;
  endtask

  task automatic exp_cyc(input string tag, input int k, input logic en, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic bsy, input logic dn, input logic er);
    check_val($sformatf("%s k%0d en", tag, k), 32'(lg_en[k]), 32'(en));
    check_val($sformatf("%s k%0d busy", tag, k), 32'(lg_busy[k]), 32'(bsy));
    check_val($sformatf("%s k%0d done", tag, k), 32'(lg_done[k]), 32'(dn));
    check_val($sformatf("%s k%0d error", tag, k), 32'(lg_err[k]), 32'(er));
    if (en) begin
      check_val($sformatf("%s k%0d we", tag, k), 32'(lg_we[k]), 32'(we));
      check_val($sformatf("%s k%0d addr", tag, k), lg_addr[k], addr);
      if (we) check_val($sformatf("%s k%0d wdata", tag, k), lg_wd[k], wd);
    end
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    src_a           = '0;
    dst_a           = '0;
    wcnt            = '0;
    bus.busWait     = 1'b0;
    bus.busReadData = '0;
    tick();
    tick();
    check_val("rst en", 32'(bus.busEnable), 32'd0);
    check_val("rst we", 32'(bus.busWrite), 32'd0);
    check_val("rst addr", bus.busAddress, 32'd0);
    check_val("rst wdata", bus.busWriteData, 32'd0);
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst done", 32'(done), 32'd0);
    check_val("rst error", 32'(error), 32'd0);
    reset = 1'b0;
    tick();

    // zero-wait copy of three words
    run(32'h100, 32'h200, 16'd3, 8, 99, 0, 0);
    exp_cyc("t1", 1, 1, 0, 32'h100, 32'h0,         1, 0, 0);
    exp_cyc("t1", 2, 1, 1, 32'h200, 32'hC0DE_0100, 1, 0, 0);
    exp_cyc("t1", 3, 1, 0, 32'h104, 32'h0,         1, 0, 0);
    exp_cyc("t1", 4, 1, 1, 32'h204, 32'hC0DE_0104, 1, 0, 0);
    exp_cyc("t1", 5, 1, 0, 32'h108, 32'h0,         1, 0, 0);
    exp_cyc("t1", 6, 1, 1, 32'h208, 32'hC0DE_0108, 1, 0, 0);
    exp_cyc("t1", 7, 0, 0, 32'h0,   32'h0,         0, 1, 0);
    exp_cyc("t1", 8, 0, 0, 32'h0,   32'h0,         0, 0, 0);

    // two wait cycles on the second read
    run(32'h300, 32'h400, 16'd2, 8, 3, 4, 0);
    exp_cyc("t2", 1, 1, 0, 32'h300, 32'h0,         1, 0, 0);
    exp_cyc("t2", 2, 1, 1, 32'h400, 32'hC0DE_0300, 1, 0, 0);
    exp_cyc("t2", 3, 1, 0, 32'h304, 32'h0,         1, 0, 0);
    exp_cyc("t2", 4, 1, 0, 32'h304, 32'h0,         1, 0, 0);
    exp_cyc("t2", 5, 1, 0, 32'h304, 32'h0,         1, 0, 0);
    exp_cyc("t2", 6, 1, 1, 32'h404, 32'hC0DE_0304, 1, 0, 0);
    exp_cyc("t2", 7, 0, 0, 32'h0,   32'h0,         0, 1, 0);
    exp_cyc("t2", 8, 0, 0, 32'h0,   32'h0,         0, 0, 0);

    // slave stalls forever on the first write: abort after 4 wait cycles
    run(32'h500, 32'h600, 16'd5, 8, 2, 99, 0);
    exp_cyc("t3", 1, 1, 0, 32'h500, 32'h0,         1, 0, 0);
    exp_cyc("t3", 2, 1, 1, 32'h600, 32'hC0DE_0500, 1, 0, 0);
    exp_cyc("t3", 3, 1, 1, 32'h600, 32'hC0DE_0500, 1, 0, 0);
    exp_cyc("t3", 4, 1, 1, 32'h600, 32'hC0DE_0500, 1, 0, 0);
    exp_cyc("t3", 5, 1, 1, 32'h600, 32'hC0DE_0500, 1, 0, 0);
    exp_cyc("t3", 6, 0, 0, 32'h0,   32'h0,         0, 0, 1);
    exp_cyc("t3", 7, 0, 0, 32'h0,   32'h0,         0, 0, 0);
    exp_cyc("t3", 8, 0, 0, 32'h0,   32'h0,         0, 0, 0);
    run(32'h610, 32'h620, 16'd1, 4, 99, 0, 0);
    exp_cyc("t3b", 1, 1, 0, 32'h610, 32'h0,         1, 0, 0);
    exp_cyc("t3b", 2, 1, 1, 32'h620, 32'hC0DE_0610, 1, 0, 0);
    exp_cyc("t3b", 3, 0, 0, 32'h0,   32'h0,         0, 1, 0);
    exp_cyc("t3b", 4, 0, 0, 32'h0,   32'h0,         0, 0, 0);

    // zero word count
    run(32'h40, 32'h80, 16'd0, 3, 99, 0, 0);
    exp_cyc("t4", 1, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    exp_cyc("t4", 2, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    exp_cyc("t4", 3, 0, 0, 32'h0, 32'h0, 0, 0, 0);

    // source address wraps past 2^32
    run(32'hFFFF_FFFC, 32'h700, 16'd2, 6, 99, 0, 0);
    exp_cyc("t5", 1, 1, 0, 32'hFFFF_FFFC, 32'h0,         1, 0, 0);
    exp_cyc("t5", 2, 1, 1, 32'h700,       32'h3F21_FFFC, 1, 0, 0);
    exp_cyc("t5", 3, 1, 0, 32'h0,         32'h0,         1, 0, 0);
    exp_cyc("t5", 4, 1, 1, 32'h704,       32'hC0DE_0000, 1, 0, 0);
    exp_cyc("t5", 5, 0, 0, 32'h0,         32'h0,         0, 1, 0);
    exp_cyc("t5", 6, 0, 0, 32'h0,         32'h0,         0, 0, 0);

    // unaligned addresses are issued aligned
    run(32'h103, 32'h802, 16'd1, 4, 99, 0, 0);
    exp_cyc("t5u", 1, 1, 0, 32'h100, 32'h0,         1, 0, 0);
    exp_cyc("t5u", 2, 1, 1, 32'h800, 32'hC0DE_0100, 1, 0, 0);
    exp_cyc("t5u", 3, 0, 0, 32'h0,   32'h0,         0, 1, 0);
    exp_cyc("t5u", 4, 0, 0, 32'h0,   32'h0,         0, 0, 0);

    // start re-pulsed mid-copy is ignored; then reset during a write
    run(32'h900, 32'hA00, 16'd4, 4, 99, 0, 2);
    exp_cyc("t6", 1, 1, 0, 32'h900, 32'h0,         1, 0, 0);
    exp_cyc("t6", 2, 1, 1, 32'hA00, 32'hC0DE_0900, 1, 0, 0);
    exp_cyc("t6", 3, 1, 0, 32'h904, 32'h0,         1, 0, 0);
    exp_cyc("t6", 4, 1, 1, 32'hA04, 32'hC0DE_0904, 1, 0, 0);
    reset = 1'b1;
    tick();
    check_val("t6 rst en", 32'(bus.busEnable), 32'd0);
    check_val("t6 rst busy", 32'(busy), 32'd0);
    check_val("t6 rst done", 32'(done), 32'd0);
    check_val("t6 rst error", 32'(error), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("t6 post%0d en", i), 32'(bus.busEnable), 32'd0);
      check_val($sformatf("t6 post%0d done", i), 32'(done), 32'd0);
      check_val($sformatf("t6 post%0d error", i), 32'(error), 32'd0);
    end
    run(32'hB00, 32'hC00, 16'd1, 3, 99, 0, 0);
    exp_cyc("t6b", 1, 1, 0, 32'hB00, 32'h0,         1, 0, 0);
    exp_cyc("t6b", 2, 1, 1, 32'hC00, 32'hC0DE_0B00, 1, 0, 0);
    exp_cyc("t6b", 3, 0, 0, 32'h0,   32'h0,         0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
